// File: rtl/cnt_wrap_logger.sv
// ============================================================================
// cnt_wrap_logger
//
// Purpose:
//   Sits after the free-running counter stage. It samples the counter value and
//   its terminal-count flag on every clock and checks that each count step is
//   legal. A legal step either holds the value or increments it by one, with
//   wrap-around. Every rising edge of the terminal flag is logged as an indexed
//   record into a small FIFO. A monitor or display stage drains that FIFO
//   through a valid/ready interface.
//
// Ports:
//   clk        in   single clock, all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   cnt_i      in   [CNT_W-1:0] counter value from the upstream counter
//   done_i     in   terminal-count flag from upstream
//   rec_valid  out  head record available
//   rec_ready  in   consumer accepts the head record
//   rec_idx    out  [IDX_W-1:0] wrap index of the head record
//   rec_err    out  sequence error seen since the previous logged record
//   ovf        out  sticky, a record was dropped because the FIFO was full
//   seq_err    out  sticky, an illegal count step was seen
// ============================================================================
module cnt_wrap_logger #(
    parameter int CNT_W = 3,
    parameter int IDX_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             done_i,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IDX_W-1:0] rec_idx,
    output logic             rec_err,
    output logic             ovf,
    output logic             seq_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [CNT_W-1:0] prev_cnt;
    logic             prev_done;
    logic             primed;
    logic [IDX_W-1:0] wrap_idx;
    logic             pending_err;
    logic             seq_err_q;
    logic             ovf_q;

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic             err_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic [CNT_W-1:0] cnt_inc;
    logic             err_now;
    logic             wrap_event;
    logic             rec_err_in;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             pending_err_nxt;

    // Step checking, event detection and FIFO handshake decisions.
    // Pop is evaluated first, so a push into a full FIFO succeeds when the
    // head leaves on the same edge. A dropped record keeps its error pending,
    // which lets the next record that is actually stored report it.
    always_comb begin
        cnt_inc         = prev_cnt + CNT_W'(1);
        err_now         = primed & (cnt_i != prev_cnt) & (cnt_i != cnt_inc);
        wrap_event      = primed & done_i & ~prev_done;
        rec_err_in      = pending_err | err_now;
        fifo_full       = (count == FULL_COUNT);
        pop             = rec_valid & rec_ready;
        push_ok         = wrap_event & (~fifo_full | pop);
        drop            = wrap_event & fifo_full & ~pop;
        pending_err_nxt = pending_err | err_now;
        if (push_ok) begin
            pending_err_nxt = 1'b0;
        end
    end

    // Input sampling, wrap index and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt    <= '0;
            prev_done   <= 1'b0;
            primed      <= 1'b0;
            wrap_idx    <= '0;
            pending_err <= 1'b0;
            seq_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            prev_cnt    <= cnt_i;
            prev_done   <= done_i;
            primed      <= 1'b1;
            pending_err <= pending_err_nxt;
            seq_err_q   <= seq_err_q | err_now;
            ovf_q       <= ovf_q | drop;
            // The index advances even on a drop. The consumer then sees a
            // gap in the indices that marks the lost records.
            if (wrap_event) begin
                wrap_idx <= wrap_idx + IDX_W'(1);
            end
        end
    end

    // FIFO storage and pointers. The storage is cleared on reset so the head
    // outputs read zero, and are X-free, before the first record arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem[i] <= '0;
                err_mem[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                idx_mem[wr_ptr] <= wrap_idx;
                err_mem[wr_ptr] <= rec_err_in;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rec_valid = (count != '0);
    assign rec_idx   = idx_mem[rd_ptr];
    assign rec_err   = err_mem[rd_ptr];
    assign ovf       = ovf_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_cnt_wrap_logger.sv
// ============================================================================
// tb_cnt_wrap_logger
//
// Purpose:
//   Directed, self-checking bench for cnt_wrap_logger. It uses the default
//   parameters (CNT_W=3, IDX_W=8, DEPTH=4). Inputs change 1 time unit after
//   each rising edge. Outputs are sampled at that same point, away from the
//   clock edge. Expected values are written by hand.
// ============================================================================
module tb_cnt_wrap_logger;

    logic       clk;
    logic       rst_n;
    logic [2:0] cnt_i;
    logic       done_i;
    logic       rec_valid;
    logic       rec_ready;
    logic [7:0] rec_idx;
    logic       rec_err;
    logic       ovf;
    logic       seq_err;

    int vectors;
    int miscompares;

    cnt_wrap_logger #(.CNT_W(3), .IDX_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_i     (cnt_i),
        .done_i    (done_i),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_idx   (rec_idx),
        .rec_err   (rec_err),
        .ovf       (ovf),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one input vector, then waits for the next rising edge plus one
    // time unit so that the registered response can be observed.
    task automatic applyStimulus(input logic [2:0] c, input logic d, input logic r);
        cnt_i     = c;
        done_i    = d;
        rec_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Makes one comparison and counts it as one applied vector.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds reset low across one rising edge while the given inputs are
    // driven, then releases it 1 time unit after an edge.
    task automatic doReset(input logic [2:0] c, input logic d, input logic r);
        cnt_i     = c;
        done_i    = d;
        rec_ready = r;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Walks the counter through one full lap, 0..7, with done raised on 7.
    task automatic oneWrap(input logic r);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(3'(c), (c == 7), r);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cnt_i       = '0;
        done_i      = 1'b0;
        rec_ready   = 1'b0;
        #3;

        // ---------------- 1: legal run ----------------
        checkOutput("rst_valid", 32'(rec_valid), 32'd0);
        checkOutput("rst_idx", 32'(rec_idx), 32'd0);
        checkOutput("rst_err", 32'(rec_err), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_seq", 32'(seq_err), 32'd0);
        doReset(3'd0, 1'b0, 1'b1);
        for (int c = 0; c < 7; c++) applyStimulus(3'(c), 1'b0, 1'b1);
        checkOutput("t1_pre_valid", 32'(rec_valid), 32'd0);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t1_r0_valid", 32'(rec_valid), 32'd1);
        checkOutput("t1_r0_idx", 32'(rec_idx), 32'd0);
        checkOutput("t1_r0_err", 32'(rec_err), 32'd0);
        applyStimulus(3'd0, 1'b0, 1'b1);
        checkOutput("t1_pop_valid", 32'(rec_valid), 32'd0);
        for (int c = 1; c < 7; c++) applyStimulus(3'(c), 1'b0, 1'b1);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t1_r1_valid", 32'(rec_valid), 32'd1);
        checkOutput("t1_r1_idx", 32'(rec_idx), 32'd1);
        checkOutput("t1_r1_err", 32'(rec_err), 32'd0);
        applyStimulus(3'd0, 1'b0, 1'b1);
        checkOutput("t1_end_valid", 32'(rec_valid), 32'd0);
        checkOutput("t1_seq", 32'(seq_err), 32'd0);
        checkOutput("t1_ovf", 32'(ovf), 32'd0);

        // ---------------- 2: illegal step ----------------
        doReset(3'd0, 1'b0, 1'b1);
        applyStimulus(3'd0, 1'b0, 1'b1);
        applyStimulus(3'd1, 1'b0, 1'b1);
        applyStimulus(3'd2, 1'b0, 1'b1);
        checkOutput("t2_seq_before", 32'(seq_err), 32'd0);
        applyStimulus(3'd5, 1'b0, 1'b1);
        checkOutput("t2_seq_after", 32'(seq_err), 32'd1);
        applyStimulus(3'd6, 1'b0, 1'b1);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t2_r0_valid", 32'(rec_valid), 32'd1);
        checkOutput("t2_r0_idx", 32'(rec_idx), 32'd0);
        checkOutput("t2_r0_err", 32'(rec_err), 32'd1);
        for (int c = 0; c < 7; c++) applyStimulus(3'(c), 1'b0, 1'b1);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t2_r1_idx", 32'(rec_idx), 32'd1);
        checkOutput("t2_r1_err", 32'(rec_err), 32'd0);
        checkOutput("t2_seq_sticky", 32'(seq_err), 32'd1);

        // ---------------- 3: backpressure and overflow ----------------
        doReset(3'd0, 1'b0, 1'b0);
        oneWrap(1'b0);
        checkOutput("t3_w1_valid", 32'(rec_valid), 32'd1);
        checkOutput("t3_w1_idx", 32'(rec_idx), 32'd0);
        oneWrap(1'b0);
        oneWrap(1'b0);
        oneWrap(1'b0);
        checkOutput("t3_w4_ovf", 32'(ovf), 32'd0);
        checkOutput("t3_w4_idx", 32'(rec_idx), 32'd0);
        oneWrap(1'b0);
        checkOutput("t3_w5_ovf", 32'(ovf), 32'd1);
        checkOutput("t3_w5_idx", 32'(rec_idx), 32'd0);
        oneWrap(1'b0);
        checkOutput("t3_w6_idx", 32'(rec_idx), 32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_drain_valid", 32'(rec_valid), 32'd1);
            checkOutput("t3_drain_idx", 32'(rec_idx), 32'(k));
            applyStimulus(3'd0, 1'b0, 1'b1);
        end
        checkOutput("t3_empty_valid", 32'(rec_valid), 32'd0);
        checkOutput("t3_seq", 32'(seq_err), 32'd0);

        // ---------------- 4: full with simultaneous push and pop ----------------
        doReset(3'd0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) oneWrap(1'b0);
        for (int c = 0; c < 7; c++) applyStimulus(3'(c), 1'b0, 1'b0);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t4_ovf", 32'(ovf), 32'd0);
        for (int k = 1; k < 5; k++) begin
            checkOutput("t4_drain_valid", 32'(rec_valid), 32'd1);
            checkOutput("t4_drain_idx", 32'(rec_idx), 32'(k));
            applyStimulus(3'd0, 1'b0, 1'b1);
        end
        checkOutput("t4_empty_valid", 32'(rec_valid), 32'd0);

        // ---------------- 5: held done and priming ----------------
        doReset(3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) applyStimulus(3'(c), 1'b0, 1'b0);
        applyStimulus(3'd7, 1'b1, 1'b0);
        applyStimulus(3'd7, 1'b1, 1'b0);
        applyStimulus(3'd7, 1'b1, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0);
        checkOutput("t5_held_idx", 32'(rec_idx), 32'd0);
        applyStimulus(3'd0, 1'b0, 1'b1);
        checkOutput("t5_held_single", 32'(rec_valid), 32'd0);
        checkOutput("t5_held_seq", 32'(seq_err), 32'd0);

        doReset(3'd7, 1'b1, 1'b1);
        applyStimulus(3'd7, 1'b1, 1'b1);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t5_prime_valid", 32'(rec_valid), 32'd0);
        applyStimulus(3'd0, 1'b0, 1'b1);
        for (int c = 1; c < 7; c++) applyStimulus(3'(c), 1'b0, 1'b1);
        checkOutput("t5_prime_quiet", 32'(rec_valid), 32'd0);
        applyStimulus(3'd7, 1'b1, 1'b1);
        checkOutput("t5_prime_rise", 32'(rec_valid), 32'd1);
        checkOutput("t5_prime_idx", 32'(rec_idx), 32'd0);

        // ---------------- 6: reset mid-operation ----------------
        doReset(3'd0, 1'b0, 1'b0);
        for (int w = 0; w < 6; w++) oneWrap(1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b1);
        applyStimulus(3'd3, 1'b0, 1'b1);
        checkOutput("t6_pre_valid", 32'(rec_valid), 32'd1);
        checkOutput("t6_pre_idx", 32'(rec_idx), 32'd2);
        checkOutput("t6_pre_ovf", 32'(ovf), 32'd1);
        checkOutput("t6_pre_seq", 32'(seq_err), 32'd1);
        rec_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(rec_valid), 32'd0);
        checkOutput("t6_async_ovf", 32'(ovf), 32'd0);
        checkOutput("t6_async_seq", 32'(seq_err), 32'd0);
        checkOutput("t6_async_idx", 32'(rec_idx), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        oneWrap(1'b1);
        checkOutput("t6_post_valid", 32'(rec_valid), 32'd1);
        checkOutput("t6_post_idx", 32'(rec_idx), 32'd0);
        checkOutput("t6_post_err", 32'(rec_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
